// File: rtl/irq_pulse_gen.sv
// irq_pulse_gen: periodic PL-to-PS interrupt source.
// Produces a one-cycle tick every PERIOD_CYCLES clocks, a PULSE_CYCLES wide
// edge interrupt, and a level interrupt held until software acks it. Ticks
// that arrive while the level interrupt is still pending are counted in a
// saturating miss counter.
// Optional build macro IRQ_PULSE_GEN_HEARTBEAT_EN adds a heartbeat toggle
// output and a 32-bit tick counter.
//
// state     | meaning
// ----------+-----------------------------------------------
// ST_IDLE   | no unacknowledged event, irq_level low
// ST_PEND   | event raised, waiting for software ack
module irq_pulse_gen #(
    parameter int PERIOD_CYCLES = 134217728,
    parameter int PULSE_CYCLES  = 256,
    parameter int MISS_W        = 8
) (
    input  logic              clk100_fclk0,
    input  logic              rstn,
    input  logic              enable,
    input  logic              ack,
    input  logic              clear_miss,
    output logic              tick,
    output logic              irq_level,
    output logic              irq_edge,
    output logic              pending,
    output logic [MISS_W-1:0] miss_count
`ifdef IRQ_PULSE_GEN_HEARTBEAT_EN
    ,
    output logic              heartbeat,
    output logic [31:0]       tick_count
`endif
);

    localparam int CNT_W = $clog2(PERIOD_CYCLES);
    localparam int PLS_W = $clog2(PULSE_CYCLES + 1);

    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(PERIOD_CYCLES - 1);
    localparam logic [PLS_W-1:0]  PLS_LOAD = PLS_W'(PULSE_CYCLES);
    localparam logic [MISS_W-1:0] MISS_MAX = '1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_PEND = 1'b1;

    generate
        if (PERIOD_CYCLES < 4) begin : g_bad_period
            $error("irq_pulse_gen: PERIOD_CYCLES must be >= 4");
        end
        if (PULSE_CYCLES < 1 || PULSE_CYCLES >= PERIOD_CYCLES) begin : g_bad_pulse
            $error("irq_pulse_gen: PULSE_CYCLES must be >= 1 and < PERIOD_CYCLES");
        end
    endgenerate

    logic [CNT_W-1:0] cnt;
    logic [PLS_W-1:0] pls_cnt;
    logic [0:0]       state;
    logic [0:0]       state_nxt;
    logic             miss_inc;

    // Period counter and registered tick strobe; disabling clears and holds.
    always_ff @(posedge clk100_fclk0) begin
        if (!rstn) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (enable) begin
            cnt  <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
            tick <= (cnt == CNT_LAST);
        end else begin
            cnt  <= '0;
            tick <= 1'b0;
        end
    end

    // Edge pulse length counter, reloaded by each tick.
    always_ff @(posedge clk100_fclk0) begin
        if (!rstn || !enable) begin
            pls_cnt <= '0;
        end else if (tick) begin
            pls_cnt <= PLS_LOAD;
        end else if (pls_cnt != '0) begin
            pls_cnt <= pls_cnt - PLS_W'(1);
        end
    end

    assign irq_edge = (pls_cnt != '0);

    // Level FSM next state; a tick+ack in PEND retires the old event and
    // raises the new one, so it is not a miss.
    always_comb begin
        state_nxt = state;
        miss_inc  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (tick) state_nxt = ST_PEND;
            end
            ST_PEND: begin
                if (ack && !tick) state_nxt = ST_IDLE;
                if (tick && !ack) miss_inc = 1'b1;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Level FSM state register; enable does not touch it.
    always_ff @(posedge clk100_fclk0) begin
        if (!rstn) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    assign pending   = (state == ST_PEND);
    assign irq_level = pending;

    // Saturating miss counter; a clear coinciding with a miss leaves one.
    always_ff @(posedge clk100_fclk0) begin
        if (!rstn) begin
            miss_count <= '0;
        end else if (clear_miss) begin
            miss_count <= miss_inc ? MISS_W'(1) : '0;
        end else if (miss_inc && (miss_count != MISS_MAX)) begin
            miss_count <= miss_count + MISS_W'(1);
        end
    end

`ifdef IRQ_PULSE_GEN_HEARTBEAT_EN
    // Heartbeat toggle and free-running tick count for board visibility.
    always_ff @(posedge clk100_fclk0) begin
        if (!rstn) begin
            heartbeat  <= 1'b0;
            tick_count <= '0;
        end else if (tick) begin
            heartbeat  <= ~heartbeat;
            tick_count <= tick_count + 32'd1;
        end
    end
`endif

endmodule

// File: doc/irq_pulse_gen.md
Name: irq_pulse_gen

Overview:
- Periodic PL-to-PS interrupt source; sits directly upstream of the PS7 IRQ_F2P inputs in the Zynq top.
- Drives one level interrupt, held until software acknowledges it, and one fixed-width pulse interrupt for a rising-edge-sensitive line.
- Replaces ad-hoc counter decoding with a handshake: pending/ack, missed-event counting, enable control.

Parameters:
PERIOD_CYCLES, 134217728, interrupt period in clocks (2^27 = 1.34 s at 100 MHz); must be >= 4
PULSE_CYCLES, 256, width of irq_edge pulse in clocks; must be >= 1 and < PERIOD_CYCLES (elaboration-time check, $error)
MISS_W, 8, width of the saturating missed-event counter

Ports:
clk100_fclk0  input  1  PS FCLK0 100 MHz; all logic on rising edge
rstn  input  1  synchronous active-low reset
enable  input  1  1 = period counter runs; 0 = counter cleared and held
ack  input  1  one-cycle (or longer) acknowledge from software, via EMIO GPIO
clear_miss  input  1  synchronous clear of miss_count
tick  output  1  one-cycle strobe at period expiry
irq_level  output  1  to IRQ_F2P, active-high level interrupt
irq_edge  output  1  to IRQ_F2P, rising-edge interrupt pulse
pending  output  1  mirror of level FSM state (1 = PEND)
miss_count  output  MISS_W  ticks that occurred while already pending, saturating

Behaviour:
- Reset: sampled only on a clock edge with rstn=0. All outputs 0; period counter 0; pulse counter 0; FSM=IDLE. Reset mid-pulse or mid-pending aborts both immediately (outputs low on the next edge).
- Period counter:
  - cnt width = $clog2(PERIOD_CYCLES).
  - If enable=1: increments, and wraps from PERIOD_CYCLES-1 to 0.
  - If enable=0: cnt <= 0.
- tick:
  - Registered; tick=1 for exactly the cycle after cnt==PERIOD_CYCLES-1 with enable=1.
  - First tick after enable rises arrives PERIOD_CYCLES cycles after the first enabled edge.
- Edge pulse:
  - On tick=1, pulse counter loads PULSE_CYCLES; irq_edge = (pulse counter != 0), registered.
  - irq_edge rises the cycle after tick and stays high exactly PULSE_CYCLES cycles.
  - enable=0 clears the pulse counter (irq_edge low next cycle).
- Level FSM, states IDLE/PEND, irq_level = pending = (state==PEND), registered:
  - IDLE: tick -> PEND. ack ignored.
  - PEND: ack & !tick -> IDLE. tick & !ack -> stay PEND, miss_count++. tick & ack -> stay PEND (ack retires old event, tick raises new one); not a miss. Neither -> stay.
  - enable=0 does not clear PEND; software must ack.
- Latency: tick at cycle N -> irq_level and irq_edge first high at N+1. ack at cycle M -> irq_level low at M+1.
- miss_count:
  - Saturates at 2^MISS_W-1.
  - clear_miss alone -> 0.
  - clear_miss concurrent with a miss increment -> 1.
- ack held high for several cycles is equivalent to a single ack (level-sampled, no edge detect).

Optional Feature:
IRQ_PULSE_GEN_HEARTBEAT_EN
- Defined:
  - Adds output port heartbeat (1 bit), toggled on every tick, reset 0. Intended for a board LED.
  - Adds output port tick_count (32 bits), incremented on every tick, wraps at 2^32, reset 0.
- Undefined: neither port exists; no extra logic.

Test Plan:
- PERIOD_CYCLES=16, PULSE_CYCLES=4, enable=1 from cycle 0 after reset -> tick at cycles 16, 32, 48; irq_edge high cycles 17-20 and 33-36; irq_level high from 17.
- Same setup, ack pulse at cycle 22 -> irq_level low from 23; rises again at 33; miss_count stays 0.
- No ack for 3 further periods -> irq_level stays high; miss_count = 3 after tick at 64. clear_miss at cycle 70 -> miss_count 0 at 71.
- ack and tick both at cycle 48 while PEND -> irq_level remains 1 continuously; miss_count unchanged.
- MISS_W=2, no ack for 6 ticks while pending -> miss_count saturates at 3. clear_miss coincident with the 7th tick -> miss_count = 1.
- rstn=0 at cycle 18 (mid-pulse, PEND) -> cycle 19 all outputs 0. enable low at cycle 10 -> cnt 0; next tick 16 cycles after enable returns high.
